// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slew-rate limited left/right motor command scheduler with emergency stop
module motor_ramp_ctrl #(
  parameter int STEP = 16,
  parameter int DIV = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] tgt_lft,
  input  logic signed [10:0] tgt_rht,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic               estop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               busy,
  output logic               at_tgt
);
  localparam int CW = $clog2(DIV);
  localparam logic signed [11:0] SD = 12'(STEP);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;
  state_t state, n_state;
  logic signed [10:0] tl, tr, n_lft, n_rht, n_tl, n_tr, cl, cr, sl, sr;
  logic [CW-1:0] cnt, n_cnt;
  logic n_at, acc, tick, same;
  function automatic logic signed [10:0] step(input logic signed [10:0] c, input logic signed [10:0] t);
    logic signed [11:0] d;
    d = {t[10], t} - {c[10], c};
    return (d <= SD && d >= -SD) ? t : (d > 0) ? c + 11'(STEP) : c - 11'(STEP);
  endfunction
  assign cmd_rdy = ~estop & (state != STOP);
  assign acc = cmd_vld & cmd_rdy;
  assign tick = (state == RAMP) & (cnt == CW'(DIV - 1));
  assign cl = (tgt_lft == 11'h400) ? 11'h401 : tgt_lft;
  assign cr = (tgt_rht == 11'h400) ? 11'h401 : tgt_rht;
  assign sl = step(lft, tl);
  assign sr = step(rht, tr);
  assign same = (cl == lft) & (cr == rht);
  assign busy = state == RAMP;
  always_comb begin
    n_state = state;
    n_lft = lft;
    n_rht = rht;
    n_tl = tl;
    n_tr = tr;
    n_cnt = cnt;
    n_at = at_tgt;
    if (estop) begin
      n_state = STOP;
      n_lft = '0;
      n_rht = '0;
      n_tl = '0;
      n_tr = '0;
      n_cnt = '0;
      n_at = 1'b1;
    end else if (state == STOP) begin
      n_state = IDLE;
    end else if (acc) begin
      n_tl = cl;
      n_tr = cr;
      n_cnt = '0;
      n_at = same;
      n_state = same ? HOLD : RAMP;
    end else if (tick) begin
      n_lft = sl;
      n_rht = sr;
      n_cnt = '0;
      n_at = (sl == tl) & (sr == tr);
      n_state = n_at ? HOLD : RAMP;
    end else if (state == RAMP) begin
      n_cnt = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lft <= '0;
      rht <= '0;
      tl <= '0;
      tr <= '0;
      cnt <= '0;
      at_tgt <= 1'b1;
    end else begin
      state <= n_state;
      lft <= n_lft;
      rht <= n_rht;
      tl <= n_tl;
      tr <= n_tr;
      cnt <= n_cnt;
      at_tgt <= n_at;
    end
  end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: scoreboard bench for the motor ramp scheduler
module tb_motor_ramp_ctrl;
  localparam int D = 4;
  localparam int S = 16;
  typedef struct {int l; int r; bit fin;} exp_t;
  logic clk = 0;
  logic rst = 1;
  logic signed [10:0] tgt_lft = '0;
  logic signed [10:0] tgt_rht = '0;
  logic cmd_vld = 0;
  logic estop = 0;
  logic cmd_rdy, busy, at_tgt;
  logic signed [10:0] lft, rht;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int ml = 0;
  int mr = 0;
  motor_ramp_ctrl #(.STEP(S), .DIV(D)) dut (
    .clk(clk), .rst(rst), .tgt_lft(tgt_lft), .tgt_rht(tgt_rht), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .estop(estop), .lft(lft), .rht(rht), .busy(busy), .at_tgt(at_tgt)
  );
  always #5 clk = ~clk;
  function automatic int stepv(int c, int t);
    int d;
    d = t - c;
    if (d <= S && d >= -S) return t;
    return d > 0 ? c + S : c - S;
  endfunction
  task automatic plan(input int tl, input int tr, input int maxn);
    exp_t e;
    int n;
    n = 0;
    while ((ml != tl || mr != tr) && n < maxn) begin
      ml = stepv(ml, tl);
      mr = stepv(mr, tr);
      e.l = ml;
      e.r = mr;
      e.fin = (ml == tl) && (mr == tr);
      q.push_back(e);
      n++;
    end
  endtask
  task automatic accept(input int l, input int r);
    @(negedge clk);
    tgt_lft = 11'(l);
    tgt_rht = 11'(r);
    cmd_vld = 1;
    @(posedge clk);
    #1;
    cmd_vld = 0;
  endtask
  task automatic drain(input string nm);
    exp_t e;
    int pl, pr, n;
    pl = lft;
    pr = rht;
    while (q.size() > 0) begin
      e = q.pop_front();
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (lft == pl && rht == pr && n < D + 2);
      checks++;
      if (lft !== e.l || rht !== e.r) begin
        failures++;
        $display("FAIL %s value: got lft=%0d rht=%0d want lft=%0d rht=%0d", nm, lft, rht, e.l, e.r);
      end
      checks++;
      if (n != D) begin
        failures++;
        $display("FAIL %s timing: step after %0d cycles want %0d", nm, n, D);
      end
      checks++;
      if (busy !== !e.fin || at_tgt !== e.fin) begin
        failures++;
        $display("FAIL %s flags: got busy=%b at_tgt=%b want busy=%b at_tgt=%b", nm, busy, at_tgt, !e.fin, e.fin);
      end
      pl = lft;
      pr = rht;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lft !== 0 || rht !== 0 || busy !== 0 || at_tgt !== 1 || cmd_rdy !== 1) begin
      failures++;
      $display("FAIL reset: got lft=%0d rht=%0d busy=%b at_tgt=%b cmd_rdy=%b want 0 0 0 1 1", lft, rht, busy, at_tgt, cmd_rdy);
    end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_ramp;
    accept(40, 40);
    checks++;
    if (lft !== 0 || rht !== 0 || busy !== 1 || at_tgt !== 0) begin
      failures++;
      $display("FAIL ramp_start: got lft=%0d rht=%0d busy=%b at_tgt=%b want 0 0 1 0", lft, rht, busy, at_tgt);
    end
    plan(40, 40, 1000);
    drain("ramp");
  endtask
  task automatic test_reversal;
    accept(-20, 40);
    plan(-20, 40, 1000);
    drain("reversal");
  endtask
  task automatic test_retarget;
    accept(0, 0);
    plan(0, 0, 1000);
    drain("retarget_home");
    accept(100, 0);
    plan(100, 0, 2);
    drain("retarget_up");
    accept(0, 0);
    plan(0, 0, 1000);
    drain("retarget_down");
  endtask
  task automatic test_estop;
    accept(100, 0);
    plan(100, 0, 3);
    drain("estop_ramp");
    @(negedge clk);
    estop = 1;
    cmd_vld = 1;
    tgt_lft = 11'sd200;
    tgt_rht = 11'sd200;
    @(posedge clk);
    #1;
    ml = 0;
    mr = 0;
    checks++;
    if (lft !== 0 || rht !== 0 || cmd_rdy !== 0 || busy !== 0 || at_tgt !== 1) begin
      failures++;
      $display("FAIL estop_hit: got lft=%0d rht=%0d cmd_rdy=%b busy=%b at_tgt=%b want 0 0 0 0 1", lft, rht, cmd_rdy, busy, at_tgt);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lft !== 0 || rht !== 0 || cmd_rdy !== 0) begin
      failures++;
      $display("FAIL estop_hold: got lft=%0d rht=%0d cmd_rdy=%b want 0 0 0", lft, rht, cmd_rdy);
    end
    @(negedge clk);
    estop = 0;
    cmd_vld = 0;
    #1;
    checks++;
    if (cmd_rdy !== 0) begin
      failures++;
      $display("FAIL estop_release_rdy: got cmd_rdy=%b want 0", cmd_rdy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_rdy !== 1 || busy !== 0) begin
      failures++;
      $display("FAIL estop_idle: got cmd_rdy=%b busy=%b want 1 0", cmd_rdy, busy);
    end
    repeat (3 * D) @(posedge clk);
    #1;
    checks++;
    if (lft !== 0 || rht !== 0 || busy !== 0 || at_tgt !== 1) begin
      failures++;
      $display("FAIL estop_not_accepted: got lft=%0d rht=%0d busy=%b at_tgt=%b want 0 0 0 1", lft, rht, busy, at_tgt);
    end
  endtask
  task automatic test_clamp_noop;
    bit saw_busy;
    accept(-1024, 1023);
    plan(-1023, 1023, 1000);
    drain("clamp");
    for (int k = 0; k < 2; k++) begin
      accept(k == 0 ? -1024 : -1023, 1023);
      saw_busy = busy;
      checks++;
      if (busy !== 0 || at_tgt !== 1) begin
        failures++;
        $display("FAIL noop%0d_accept: got busy=%b at_tgt=%b want 0 1", k, busy, at_tgt);
      end
      repeat (2 * D) begin
        @(posedge clk);
        #1;
        saw_busy |= busy;
      end
      checks++;
      if (saw_busy || lft !== -1023 || rht !== 1023) begin
        failures++;
        $display("FAIL noop%0d_hold: got busy_seen=%b lft=%0d rht=%0d want 0 -1023 1023", k, saw_busy, lft, rht);
      end
    end
  endtask
  task automatic test_async_reset;
    accept(300, -300);
    plan(300, -300, 2);
    drain("pre_reset");
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    ml = 0;
    mr = 0;
    q.delete();
    checks++;
    if (lft !== 0 || rht !== 0 || busy !== 0 || at_tgt !== 1) begin
      failures++;
      $display("FAIL async_reset: got lft=%0d rht=%0d busy=%b at_tgt=%b want 0 0 0 1", lft, rht, busy, at_tgt);
    end
    @(negedge clk);
    rst = 0;
    repeat (3 * D) @(posedge clk);
    #1;
    checks++;
    if (lft !== 0 || rht !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL no_resume: got lft=%0d rht=%0d busy=%b want 0 0 0", lft, rht, busy);
    end
  endtask
  initial begin
    test_reset;
    test_ramp;
    test_reversal;
    test_retarget;
    test_estop;
    test_clamp_noop;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
